mp_control_v2: RTL and testbench

- Parametrised successor to the multicycle RV32I control FSM.
- Adds the following over the first generation:
  - full JAL/JALR/register-register sequencing;
  - sub-word load/store byte-enable generation;
  - misalignment and illegal-opcode detection;
  - a memory-response timeout;
  - a sticky trap/halt state.
- Sits between the datapath (opcode/funct fields, br_en, effective-address low bits) and the single unified memory port.

---
 rtl/mp_control_v2_pkg.sv | 65 ++++++
 rtl/mp_control_v2_be_gen.sv | 31 +++
 rtl/mp_control_v2.sv | 276 +++++++++++++++++++++++++++
 tb/tb_mp_control_v2.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mp_control_v2_pkg.sv
// Shared types for the multicycle RV32I control path: opcodes, funct3 encodings,
// datapath mux selects, FSM states and trap causes.
package mp_control_v2_pkg;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef enum logic [2:0] {
    beq  = 3'b000, bne  = 3'b001, blt  = 3'b100,
    bge  = 3'b101, bltu = 3'b110, bgeu = 3'b111
  } branch_funct3_t;

  typedef enum logic [2:0] {
    f3_add = 3'b000, f3_sll  = 3'b001, f3_slt = 3'b010, f3_sltu = 3'b011,
    f3_xor = 3'b100, f3_sr   = 3'b101, f3_or  = 3'b110, f3_and  = 3'b111
  } arith_funct3_t;

  typedef enum logic [2:0] {
    lb = 3'b000, lh = 3'b001, lw = 3'b010, lbu = 3'b100, lhu = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    sb = 3'b000, sh = 3'b001, sw = 3'b010
  } store_funct3_t;

  typedef enum logic [2:0] {
    alu_add = 3'b000, alu_sll = 3'b001, alu_sra = 3'b010, alu_sub = 3'b011,
    alu_xor = 3'b100, alu_srl = 3'b101, alu_or  = 3'b110, alu_and = 3'b111
  } alu_ops;

  typedef enum logic [1:0] {
    PCMUX_PC4 = 2'd0, PCMUX_ALU = 2'd1, PCMUX_ALU_MOD2 = 2'd2
  } pcmux_sel_t;

  typedef enum logic [2:0] {
    ALUMUX2_I = 3'd0, ALUMUX2_U = 3'd1, ALUMUX2_B = 3'd2,
    ALUMUX2_S = 3'd3, ALUMUX2_J = 3'd4, ALUMUX2_RS2 = 3'd5
  } alumux2_sel_t;

  typedef enum logic [2:0] {
    RFMUX_ALU = 3'd0, RFMUX_CMP = 3'd1, RFMUX_UIMM = 3'd2,
    RFMUX_MDR = 3'd3, RFMUX_PC4 = 3'd4
  } regfilemux_sel_t;

  typedef enum logic [1:0] {
    TRAP_NONE = 2'd0, TRAP_ILLEGAL = 2'd1, TRAP_MISALIGN = 2'd2, TRAP_TIMEOUT = 2'd3
  } trap_cause_t;

  typedef enum logic [4:0] {
    S_FETCH1, S_FETCH2, S_FETCH3, S_DECODE,
    S_LUI, S_AUIPC, S_JAL, S_JALR, S_BR, S_IMM, S_REG,
    S_CALC_ADDR, S_LD1, S_LD2, S_ST1, S_ST2, S_TRAP
  } ctrl_state_t;

endpackage

// File: rtl/mp_control_v2_be_gen.sv
// Byte-enable and alignment check for a sub-word memory access at a given lane offset.
module mem_be_gen
  import mp_control_v2_pkg::*;
#(
  parameter int BYTE_LANES = 4,
  localparam int OFFW = $clog2(BYTE_LANES)
) (
  input  logic [1:0]            size_i,
  input  logic [OFFW-1:0]       offset_i,
  output logic [BYTE_LANES-1:0] byte_enable_o,
  output logic                  misaligned_o
);

  always_comb begin
    byte_enable_o = '1;
    misaligned_o  = 1'b0;
    unique case (size_i)
      2'd0: byte_enable_o = BYTE_LANES'(1) << offset_i;
      2'd1: begin
        byte_enable_o = BYTE_LANES'(3) << offset_i;
        misaligned_o  = offset_i[0];
      end
      default: begin
        // Word enables never spill past lane 3, even on wider buses.
        byte_enable_o = (BYTE_LANES'(15) << offset_i) & BYTE_LANES'(15);
        misaligned_o  = |offset_i[1:0];
      end
    endcase
  end

endmodule

// File: rtl/mp_control_v2.sv
// Multicycle RV32I control FSM driving a single unified memory port, with sub-word
// byte enables, alignment/illegal-opcode detection, response timeout and sticky trap.
module mp_control_v2
  import mp_control_v2_pkg::*;
#(
  parameter int BYTE_LANES  = 4,
  parameter int MEM_TIMEOUT = 0,
  parameter int TCW         = 16,
  localparam int OFFW = $clog2(BYTE_LANES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic                  br_en,
  input  logic [OFFW-1:0]       addr_lsb,
  input  logic                  mem_resp,
  output logic                  load_pc,
  output logic                  load_ir,
  output logic                  load_regfile,
  output logic                  load_mar,
  output logic                  load_mdr,
  output logic                  load_data_out,
  output logic [1:0]            pcmux_sel,
  output logic [2:0]            cmpop,
  output logic                  cmpmux_sel,
  output logic                  alumux1_sel,
  output logic [2:0]            alumux2_sel,
  output logic [2:0]            aluop,
  output logic [2:0]            regfilemux_sel,
  output logic                  marmux_sel,
  output logic [2:0]            ld_funct3,
  output logic [OFFW-1:0]       ld_offset,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [BYTE_LANES-1:0] mem_byte_enable,
  output logic                  trap,
  output logic [1:0]            trap_cause
);

  ctrl_state_t     state_q, state_d;
  logic [TCW-1:0]  tcnt_q, tcnt_d;
  logic [2:0]      ld_funct3_q, ld_funct3_d;
  logic [OFFW-1:0] ld_offset_q, ld_offset_d;
  logic            trap_q;
  logic [1:0]      trap_cause_q, trap_cause_d;

  logic                  waiting, expired, is_store, misaligned;
  logic [1:0]            be_size;
  logic [OFFW-1:0]       be_offset;
  logic [BYTE_LANES-1:0] be_mask;
  logic                  unused_funct7;

  assign unused_funct7 = ^{funct7[6], funct7[4:0]};
  assign is_store      = (opcode == op_store);

  // The alignment check looks at the live address; store enables use the latched one.
  assign be_size   = (state_q == S_CALC_ADDR) ? funct3[1:0] : ld_funct3_q[1:0];
  assign be_offset = (state_q == S_CALC_ADDR) ? addr_lsb    : ld_offset_q;

  mem_be_gen #(.BYTE_LANES(BYTE_LANES)) u_be_gen (
    .size_i        (be_size),
    .offset_i      (be_offset),
    .byte_enable_o (be_mask),
    .misaligned_o  (misaligned)
  );

  assign waiting = (state_q == S_FETCH2) || (state_q == S_LD1) || (state_q == S_ST1);
  assign tcnt_d  = (waiting && !mem_resp) ? tcnt_q + TCW'(1) : '0;

  generate
    if (MEM_TIMEOUT > 0) begin : g_timeout
      assign expired = waiting && !mem_resp && (tcnt_q == TCW'(MEM_TIMEOUT - 1));
    end else begin : g_no_timeout
      assign expired = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_FETCH1;
      tcnt_q       <= '0;
      ld_funct3_q  <= '0;
      ld_offset_q  <= '0;
      trap_q       <= 1'b0;
      trap_cause_q <= TRAP_NONE;
    end else begin
      state_q      <= state_d;
      tcnt_q       <= tcnt_d;
      ld_funct3_q  <= ld_funct3_d;
      ld_offset_q  <= ld_offset_d;
      trap_q       <= (state_d == S_TRAP);
      trap_cause_q <= trap_cause_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    trap_cause_d    = trap_cause_q;
    ld_funct3_d     = ld_funct3_q;
    ld_offset_d     = ld_offset_q;
    load_pc         = 1'b0;
    load_ir         = 1'b0;
    load_regfile    = 1'b0;
    load_mar        = 1'b0;
    load_mdr        = 1'b0;
    load_data_out   = 1'b0;
    pcmux_sel       = PCMUX_PC4;
    cmpop           = funct3;
    cmpmux_sel      = 1'b0;
    alumux1_sel     = 1'b0;
    alumux2_sel     = ALUMUX2_I;
    aluop           = funct3;
    regfilemux_sel  = RFMUX_ALU;
    marmux_sel      = 1'b0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_byte_enable = '1;
    // Outputs stay at their defaults for as long as reset is held.
    if (rst_n) begin
      unique case (state_q)
        S_FETCH1: begin
          load_mar = 1'b1;
          state_d  = S_FETCH2;
        end
        S_FETCH2: begin
          mem_read = 1'b1;
          load_mdr = 1'b1;
          if (mem_resp) state_d = S_FETCH3;
          else if (expired) begin
            state_d      = S_TRAP;
            trap_cause_d = TRAP_TIMEOUT;
          end
        end
        S_FETCH3: begin
          load_ir = 1'b1;
          state_d = S_DECODE;
        end
        S_DECODE: begin
          case (opcode)
            op_lui:            state_d = S_LUI;
            op_auipc:          state_d = S_AUIPC;
            op_jal:            state_d = S_JAL;
            op_jalr:           state_d = S_JALR;
            op_br:             state_d = S_BR;
            op_imm:            state_d = S_IMM;
            op_reg:            state_d = S_REG;
            op_load, op_store: state_d = S_CALC_ADDR;
            default: begin
              state_d      = S_TRAP;
              trap_cause_d = TRAP_ILLEGAL;
            end
          endcase
        end
        S_LUI: begin
          load_regfile   = 1'b1;
          regfilemux_sel = RFMUX_UIMM;
          load_pc        = 1'b1;
          state_d        = S_FETCH1;
        end
        S_AUIPC: begin
          alumux1_sel  = 1'b1;
          alumux2_sel  = ALUMUX2_U;
          aluop        = alu_add;
          load_regfile = 1'b1;
          load_pc      = 1'b1;
          state_d      = S_FETCH1;
        end
        S_JAL: begin
          alumux1_sel    = 1'b1;
          alumux2_sel    = ALUMUX2_J;
          aluop          = alu_add;
          pcmux_sel      = PCMUX_ALU;
          regfilemux_sel = RFMUX_PC4;
          load_regfile   = 1'b1;
          load_pc        = 1'b1;
          state_d        = S_FETCH1;
        end
        S_JALR: begin
          aluop          = alu_add;
          pcmux_sel      = PCMUX_ALU_MOD2;
          regfilemux_sel = RFMUX_PC4;
          load_regfile   = 1'b1;
          load_pc        = 1'b1;
          state_d        = S_FETCH1;
        end
        S_BR: begin
          alumux1_sel = 1'b1;
          alumux2_sel = ALUMUX2_B;
          aluop       = alu_add;
          pcmux_sel   = {1'b0, br_en};
          load_pc     = 1'b1;
          state_d     = S_FETCH1;
        end
        S_IMM: begin
          load_regfile = 1'b1;
          load_pc      = 1'b1;
          state_d      = S_FETCH1;
          if (funct3 == f3_slt || funct3 == f3_sltu) begin
            cmpop          = (funct3 == f3_slt) ? blt : bltu;
            cmpmux_sel     = 1'b1;
            regfilemux_sel = RFMUX_CMP;
          end else if (funct3 == f3_sr && funct7[5]) begin
            aluop = alu_sra;
          end
        end
        S_REG: begin
          alumux2_sel  = ALUMUX2_RS2;
          load_regfile = 1'b1;
          load_pc      = 1'b1;
          state_d      = S_FETCH1;
          if (funct3 == f3_slt || funct3 == f3_sltu) begin
            cmpop          = (funct3 == f3_slt) ? blt : bltu;
            regfilemux_sel = RFMUX_CMP;
          end else if (funct3 == f3_add && funct7[5]) begin
            aluop = alu_sub;
          end else if (funct3 == f3_sr && funct7[5]) begin
            aluop = alu_sra;
          end
        end
        S_CALC_ADDR: begin
          aluop         = alu_add;
          alumux2_sel   = is_store ? ALUMUX2_S : ALUMUX2_I;
          marmux_sel    = 1'b1;
          load_mar      = 1'b1;
          load_data_out = is_store;
          ld_funct3_d   = funct3;
          ld_offset_d   = addr_lsb;
          if (misaligned) begin
            state_d      = S_TRAP;
            trap_cause_d = TRAP_MISALIGN;
          end else begin
            state_d = is_store ? S_ST1 : S_LD1;
          end
        end
        S_LD1: begin
          mem_read = 1'b1;
          load_mdr = 1'b1;
          if (mem_resp) state_d = S_LD2;
          else if (expired) begin
            state_d      = S_TRAP;
            trap_cause_d = TRAP_TIMEOUT;
          end
        end
        S_LD2: begin
          regfilemux_sel = RFMUX_MDR;
          load_regfile   = 1'b1;
          load_pc        = 1'b1;
          state_d        = S_FETCH1;
        end
        S_ST1: begin
          mem_write       = 1'b1;
          mem_byte_enable = be_mask;
          if (mem_resp) state_d = S_ST2;
          else if (expired) begin
            state_d      = S_TRAP;
            trap_cause_d = TRAP_TIMEOUT;
          end
        end
        S_ST2: begin
          load_pc = 1'b1;
          state_d = S_FETCH1;
        end
        S_TRAP: state_d = S_TRAP;
        default: state_d = S_FETCH1;
      endcase
    end
  end

  assign ld_funct3  = ld_funct3_q;
  assign ld_offset  = ld_offset_q;
  assign trap       = trap_q;
  assign trap_cause = trap_cause_q;

endmodule

// File: tb/tb_mp_control_v2.sv
// Directed-vector bench for mp_control_v2 (4 byte lanes, 4-cycle memory timeout).
module tb_mp_control_v2;

  localparam int BL = 4;
  localparam int OW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [6:0]    opcode = '0;
  logic [2:0]    funct3 = '0;
  logic [6:0]    funct7 = '0;
  logic          br_en = 1'b0;
  logic [OW-1:0] addr_lsb = '0;
  logic          mem_resp = 1'b0;

  logic          load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out;
  logic [1:0]    pcmux_sel;
  logic [2:0]    cmpop;
  logic          cmpmux_sel, alumux1_sel;
  logic [2:0]    alumux2_sel, aluop, regfilemux_sel;
  logic          marmux_sel;
  logic [2:0]    ld_funct3;
  logic [OW-1:0] ld_offset;
  logic          mem_read, mem_write;
  logic [BL-1:0] mem_byte_enable;
  logic          trap;
  logic [1:0]    trap_cause;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mp_control_v2 #(.BYTE_LANES(BL), .MEM_TIMEOUT(4), .TCW(16)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .br_en(br_en), .addr_lsb(addr_lsb), .mem_resp(mem_resp),
    .load_pc(load_pc), .load_ir(load_ir), .load_regfile(load_regfile),
    .load_mar(load_mar), .load_mdr(load_mdr), .load_data_out(load_data_out),
    .pcmux_sel(pcmux_sel), .cmpop(cmpop), .cmpmux_sel(cmpmux_sel),
    .alumux1_sel(alumux1_sel), .alumux2_sel(alumux2_sel), .aluop(aluop),
    .regfilemux_sel(regfilemux_sel), .marmux_sel(marmux_sel),
    .ld_funct3(ld_funct3), .ld_offset(ld_offset), .mem_read(mem_read),
    .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
    .trap(trap), .trap_cause(trap_cause)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the FSM in FETCH1, one time unit after a rising edge.
  task automatic do_reset();
    mem_resp = 1'b0;
    br_en    = 1'b0;
    addr_lsb = '0;
    rst_n    = 1'b0;
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // From FETCH1: fetch with mem_resp on the waits-th FETCH2 cycle, stop in the state after DECODE.
  task automatic fetch_to_exec(input logic [6:0] op, input logic [2:0] f3,
                               input logic [6:0] f7, input int waits);
    opcode   = op;
    funct3   = f3;
    funct7   = f7;
    mem_resp = 1'b0;
    #1;
    check("f1_load_mar", 32'(load_mar), 1);
    tick();
    for (int i = 1; i <= waits; i++) begin
      mem_resp = (i == waits);
      #1;
      check("f2_mem_read", 32'({mem_read, load_mdr}), 3);
      tick();
    end
    mem_resp = 1'b0;
    #1;
    check("f3_load_ir", 32'(load_ir), 1);
    tick();
    check("decode_idle", 32'({load_pc, load_regfile, mem_read, load_ir}), 0);
    tick();
  endtask

  task automatic do_store(input string tag, input logic [2:0] f3,
                          input logic [OW-1:0] lsb, input logic [BL-1:0] exp_be);
    fetch_to_exec(7'h23, f3, 7'h00, 1);
    addr_lsb = lsb;
    #1;
    check({tag, "_calc"}, 32'({load_mar, marmux_sel, load_data_out, alumux2_sel, mem_write}), 32'b111_011_0);
    tick();
    check({tag, "_be"}, 32'(mem_byte_enable), 32'(exp_be));
    check({tag, "_st1"}, 32'({mem_write, mem_read, ld_offset}), 32'({2'b10, lsb}));
    tick();
    mem_resp = 1'b1;
    #1;
    check({tag, "_st1_hold"}, 32'(mem_write), 1);
    tick();
    mem_resp = 1'b0;
    #1;
    check({tag, "_st2"}, 32'({load_pc, mem_write, mem_byte_enable}), 32'b1_0_1111);
    tick();
    $display("txn %s f3=%0d lsb=%0d be=%b", tag, f3, lsb, exp_be);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset defaults, with funct3 passed through to aluop/cmpop
    funct3 = 3'b110;
    #2;
    check("rst_strobes", 32'({load_mar, load_pc, load_ir, mem_read, mem_write}), 0);
    check("rst_be", 32'(mem_byte_enable), 32'hF);
    check("rst_aluop", 32'(aluop), 6);
    check("rst_cmpop", 32'(cmpop), 6);
    check("rst_trap", 32'({trap, trap_cause}), 0);
    check("rst_ld_regs", 32'({ld_funct3, ld_offset}), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    $display("txn reset: defaults");

    // ADDI x1,x0,5: FETCH1, FETCH2 x3, FETCH3, DECODE, IMM
    fetch_to_exec(7'h13, 3'b000, 7'h00, 3);
    check("addi_imm", 32'({load_regfile, load_pc, aluop, regfilemux_sel, alumux2_sel}), 32'b11_000_000_000);
    tick();
    check("addi_back_f1", 32'(load_mar), 1);
    $display("txn ADDI x1,x0,5");

    fetch_to_exec(7'h13, 3'b101, 7'h20, 1);
    check("srai_aluop", 32'(aluop), 2);
    tick();
    $display("txn SRAI");

    fetch_to_exec(7'h13, 3'b011, 7'h00, 2);
    check("sltiu_cmp", 32'({cmpop, cmpmux_sel, regfilemux_sel}), 32'b110_1_001);
    tick();
    $display("txn SLTIU");

    fetch_to_exec(7'h33, 3'b000, 7'h20, 1);
    check("sub_alu", 32'({aluop, alumux2_sel, load_regfile}), 32'b011_101_1);
    tick();
    $display("txn SUB");

    fetch_to_exec(7'h33, 3'b010, 7'h00, 1);
    check("slt_cmp", 32'({cmpop, cmpmux_sel, regfilemux_sel, alumux2_sel}), 32'b100_0_001_101);
    tick();
    $display("txn SLT");

    fetch_to_exec(7'h63, 3'b101, 7'h00, 1);
    br_en = 1'b1;
    #1;
    check("bge_taken", 32'({pcmux_sel, alumux1_sel, alumux2_sel, cmpop, load_pc}), 32'b01_1_010_101_1);
    tick();
    br_en = 1'b0;
    $display("txn BGE taken");

    // JALR with alu = 0x1003: pc gets alu & ~1 via pcmux 2
    fetch_to_exec(7'h67, 3'b000, 7'h00, 1);
    check("jalr_sel", 32'({pcmux_sel, regfilemux_sel, load_regfile, load_pc, alumux1_sel, alumux2_sel}),
          32'b10_100_1_1_0_000);
    tick();
    $display("txn JALR");

    do_store("sb", 3'b000, 2'd2, 4'b0100);
    do_store("sh", 3'b001, 2'd2, 4'b1100);
    do_store("sw", 3'b010, 2'd0, 4'b1111);

    fetch_to_exec(7'h03, 3'b010, 7'h00, 1);
    addr_lsb = 2'd0;
    #1;
    check("lw_calc", 32'({load_mar, marmux_sel, load_data_out, mem_read, trap}), 32'b11000);
    tick();
    check("lw_ld1", 32'({mem_read, load_mdr, ld_funct3}), 32'b11_010);
    tick();
    mem_resp = 1'b1;
    tick();
    mem_resp = 1'b0;
    #1;
    check("lw_ld2", 32'({regfilemux_sel, load_regfile, load_pc, mem_read}), 32'b011_1_1_0);
    tick();
    $display("txn LW lsb=0");

    // LH at odd address: trap without ever reading memory
    fetch_to_exec(7'h03, 3'b001, 7'h00, 1);
    addr_lsb = 2'd1;
    #1;
    check("lh_calc_no_read", 32'({mem_read, load_mar}), 32'b01);
    tick();
    check("lh_trap", 32'({trap, trap_cause, mem_read}), 32'b1_10_0);
    for (int i = 0; i < 3; i++) begin
      mem_resp = ~mem_resp;
      tick();
    end
    check("lh_trap_held", 32'({trap, trap_cause, mem_read, load_mar, load_pc}), 32'b1_10_000);
    rst_n = 1'b0;
    #1;
    check("lh_trap_cleared", 32'({trap, trap_cause}), 0);
    do_reset();
    $display("txn LH misaligned");

    fetch_to_exec(7'h7F, 3'b000, 7'h00, 1);
    check("illegal_trap", 32'({trap, trap_cause, load_pc}), 32'b1_01_0);
    do_reset();
    $display("txn illegal opcode 0x7F");

    // Timeout: no response for 4 FETCH2 cycles
    tick();
    for (int i = 1; i <= 4; i++) begin
      check("to_wait", 32'({mem_read, trap}), 32'b10);
      tick();
    end
    check("to_trap", 32'({trap, trap_cause, mem_read, load_mdr}), 32'b1_11_00);
    do_reset();
    $display("txn timeout expiry");

    tick();
    for (int i = 1; i <= 4; i++) begin
      mem_resp = (i == 4);
      #1;
      check("to_resp_wait", 32'(mem_read), 1);
      tick();
    end
    mem_resp = 1'b0;
    #1;
    check("to_resp_f3", 32'({load_ir, trap}), 32'b10);
    do_reset();
    $display("txn response on expiry cycle");

    // Reset asserted in the middle of an LD1 wait
    fetch_to_exec(7'h03, 3'b100, 7'h00, 1);
    addr_lsb = 2'd3;
    #1;
    check("lbu_calc", 32'(trap), 0);
    tick();
    check("lbu_ld1", 32'({mem_read, ld_funct3, ld_offset}), 32'b1_100_11);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out", 32'({mem_read, load_mdr, load_mar, mem_byte_enable}), 32'b000_1111);
    check("mid_rst_regs", 32'({ld_funct3, ld_offset}), 0);
    mem_resp = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("mid_rst_f1", 32'({load_mar, mem_read}), 32'b10);
    tick();
    check("late_resp_ignored", 32'({mem_read, load_ir}), 32'b10);
    mem_resp = 1'b0;
    $display("txn reset during LD1");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
